// File: rtl/pipe_rca_adder.sv
// rtl/pipe_rca_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready flow control
// Optional signed-overflow output enabled by defining PIPE_RCA_OVF_EN.
module pipe_rca_adder #(
    parameter int WIDTH  = 51,
    parameter int STAGES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
`ifdef PIPE_RCA_OVF_EN
    output logic             o_overflow,
`endif
    output logic [WIDTH:0]   o_result
);

    localparam int CH = (WIDTH + STAGES - 1) / STAGES;

    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
`ifdef PIPE_RCA_OVF_EN
    logic             m_q [STAGES];
    logic             m_d [STAGES];
`endif

    logic stall;

    // Ripples only the bits of chunk k; bits outside the chunk pass through untouched.
    // m tracks the carry entering the MSB, captured by whichever stage owns bit WIDTH-1.
    function automatic void add_chunk(
        input  int               k,
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        input  logic [WIDTH-1:0] s_in,
        input  logic             c_in,
`ifdef PIPE_RCA_OVF_EN
        input  logic             m_in,
        output logic             m_out,
`endif
        output logic [WIDTH-1:0] s_out,
        output logic             c_out
    );
        s_out = s_in;
        c_out = c_in;
`ifdef PIPE_RCA_OVF_EN
        m_out = m_in;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= k * CH && i < (k + 1) * CH) begin
`ifdef PIPE_RCA_OVF_EN
                if (i == WIDTH - 1) m_out = c_out;
`endif
                s_out[i] = a[i] ^ b[i] ^ c_out;
                c_out    = (a[i] & b[i]) | (c_out & (a[i] ^ b[i]));
            end
        end
    endfunction

    assign stall   = v_q[STAGES-1] & ~i_ready;
    assign o_ready = i_ready | ~v_q[STAGES-1];

    always_comb begin
        v_d[0] = i_valid;
        a_d[0] = i_add_term1;
        b_d[0] = i_add_term2 ^ {WIDTH{i_sub}};
`ifdef PIPE_RCA_OVF_EN
        add_chunk(0, a_d[0], b_d[0], '0, i_sub, 1'b0, m_d[0], s_d[0], c_d[0]);
`else
        add_chunk(0, a_d[0], b_d[0], '0, i_sub, s_d[0], c_d[0]);
`endif
        for (int k = 1; k < STAGES; k++) begin
            v_d[k] = v_q[k-1];
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
`ifdef PIPE_RCA_OVF_EN
            add_chunk(k, a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], m_q[k-1], m_d[k], s_d[k], c_d[k]);
`else
            add_chunk(k, a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], s_d[k], c_d[k]);
`endif
        end
    end

    // A stall freezes every stage, bubbles included, so ordering and spacing are preserved.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
`ifdef PIPE_RCA_OVF_EN
                m_q[k] <= 1'b0;
`endif
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
`ifdef PIPE_RCA_OVF_EN
                m_q[k] <= m_d[k];
`endif
            end
        end
    end

    assign o_valid  = v_q[STAGES-1];
    assign o_result = {c_q[STAGES-1], s_q[STAGES-1]};
`ifdef PIPE_RCA_OVF_EN
    assign o_overflow = m_q[STAGES-1] ^ c_q[STAGES-1];
`endif

endmodule
